// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes, functs,
// ALU operation codes and datapath mux selects.
package mips_ctrl_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 4;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_WB_ALU   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [OP_W-1:0] F_SLL  = 6'h00;
  localparam logic [OP_W-1:0] F_SRL  = 6'h02;
  localparam logic [OP_W-1:0] F_SRA  = 6'h03;
  localparam logic [OP_W-1:0] F_SLLV = 6'h04;
  localparam logic [OP_W-1:0] F_SRLV = 6'h06;
  localparam logic [OP_W-1:0] F_SRAV = 6'h07;
  localparam logic [OP_W-1:0] F_JR   = 6'h08;
  localparam logic [OP_W-1:0] F_JALR = 6'h09;
  localparam logic [OP_W-1:0] F_ADD  = 6'h20;
  localparam logic [OP_W-1:0] F_ADDU = 6'h21;
  localparam logic [OP_W-1:0] F_SUB  = 6'h22;
  localparam logic [OP_W-1:0] F_SUBU = 6'h23;
  localparam logic [OP_W-1:0] F_AND  = 6'h24;
  localparam logic [OP_W-1:0] F_OR   = 6'h25;
  localparam logic [OP_W-1:0] F_XOR  = 6'h26;
  localparam logic [OP_W-1:0] F_NOR  = 6'h27;
  localparam logic [OP_W-1:0] F_SLT  = 6'h2A;
  localparam logic [OP_W-1:0] F_SLTU = 6'h2B;

  localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'b0001;
  localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'b0010;
  localparam logic [ALUOP_W-1:0] ALU_AND  = 4'b0011;
  localparam logic [ALUOP_W-1:0] ALU_OR   = 4'b0100;
  localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'b0101;
  localparam logic [ALUOP_W-1:0] ALU_SLTU = 4'b0110;
  localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'b1000;
  localparam logic [ALUOP_W-1:0] ALU_SRL  = 4'b1001;
  localparam logic [ALUOP_W-1:0] ALU_SRA  = 4'b1010;
  localparam logic [ALUOP_W-1:0] ALU_LUI  = 4'b1100;
  localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'b1101;
  localparam logic [ALUOP_W-1:0] ALU_NOR  = 4'b1110;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  localparam logic [1:0] ASA_PC    = 2'd0;
  localparam logic [1:0] ASA_RS    = 2'd1;
  localparam logic [1:0] ASA_SHAMT = 2'd2;

  localparam logic [1:0] ASB_RT      = 2'd0;
  localparam logic [1:0] ASB_FOUR    = 2'd1;
  localparam logic [1:0] ASB_IMM     = 2'd2;
  localparam logic [1:0] ASB_IMM_SH2 = 2'd3;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational (Opcode, Funct) -> ALU operation, immediate extension and
// instruction-class flags for the R-type and I-type ALU instructions.
module alu_op_decode
  import mips_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]    opcode,
  input  logic [OP_W-1:0]    funct,
  output logic [ALUOP_W-1:0] alu_op_c,
  output logic               ext_op_c,
  output logic               shift_c,
  output logic               r_alu_c,
  output logic               i_alu_c
);

  always_comb begin
    alu_op_c = ALU_ADD;
    ext_op_c = 1'b0;
    shift_c  = 1'b0;
    r_alu_c  = 1'b0;
    i_alu_c  = 1'b0;
    if (opcode == OP_RTYPE) begin
      r_alu_c = 1'b1;
      case (funct)
        F_ADD, F_ADDU: alu_op_c = ALU_ADD;
        F_SUB, F_SUBU: alu_op_c = ALU_SUB;
        F_AND:         alu_op_c = ALU_AND;
        F_OR:          alu_op_c = ALU_OR;
        F_XOR:         alu_op_c = ALU_XOR;
        F_NOR:         alu_op_c = ALU_NOR;
        F_SLT:         alu_op_c = ALU_SLT;
        F_SLTU:        alu_op_c = ALU_SLTU;
        F_SLL, F_SLLV: begin alu_op_c = ALU_SLL; shift_c = 1'b1; end
        F_SRL, F_SRLV: begin alu_op_c = ALU_SRL; shift_c = 1'b1; end
        F_SRA, F_SRAV: begin alu_op_c = ALU_SRA; shift_c = 1'b1; end
        default:       r_alu_c = 1'b0;
      endcase
    end else begin
      i_alu_c = 1'b1;
      case (opcode)
        OP_ADDI: begin alu_op_c = ALU_ADD; ext_op_c = 1'b1; end
        OP_SLTI: begin alu_op_c = ALU_SLT; ext_op_c = 1'b1; end
        OP_ANDI: alu_op_c = ALU_AND;
        OP_ORI:  alu_op_c = ALU_OR;
        OP_LUI:  alu_op_c = ALU_LUI;
        default: i_alu_c = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control FSM: sequences the shared ALU and unified memory port,
// stalls on mem_ready and abandons an access after MEM_WAIT_MAX stall cycles.
module multi_cycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    Opcode,
  input  logic [OP_W-1:0]    Funct,
  input  logic               Zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic [1:0]         PCSrc,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               EXTOP,
  output logic               illegal,
  output logic               mem_timeout,
  output logic [3:0]         state_o
);

  localparam int unsigned WAIT_W =
    ($clog2(MEM_WAIT_MAX + 1) < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [ALUOP_W-1:0]  dec_alu_op;
  logic                dec_ext, dec_shift, dec_r_alu, dec_i_alu;
  logic                is_r, is_j, is_jal, is_jr, is_jalr, is_beq, is_bne, is_lw, is_sw;
  logic                mem_wait_st;

  alu_op_decode u_alu_op_decode (
    .opcode   (Opcode),
    .funct    (Funct),
    .alu_op_c (dec_alu_op),
    .ext_op_c (dec_ext),
    .shift_c  (dec_shift),
    .r_alu_c  (dec_r_alu),
    .i_alu_c  (dec_i_alu)
  );

  assign is_r    = (Opcode == OP_RTYPE);
  assign is_jr   = is_r && (Funct == F_JR);
  assign is_jalr = is_r && (Funct == F_JALR);
  assign is_j    = (Opcode == OP_J);
  assign is_jal  = (Opcode == OP_JAL);
  assign is_beq  = (Opcode == OP_BEQ);
  assign is_bne  = (Opcode == OP_BNE);
  assign is_lw   = (Opcode == OP_LW);
  assign is_sw   = (Opcode == OP_SW);
  assign mem_wait_st = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign state_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    PCWrite     = 1'b0;
    PCSrc       = PCSRC_ALU;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = REGDST_RT;
    MemtoReg    = M2R_ALUOUT;
    ALUSrcA     = ASA_PC;
    ALUSrcB     = ASB_RT;
    ALUOp       = '0;
    EXTOP       = 1'b0;
    illegal     = 1'b0;
    mem_timeout = 1'b0;

    // Stall accounting; a completion in the limit cycle wins over the timeout.
    if (mem_wait_st && !mem_ready) begin
      if (wait_q == WAIT_W'(MEM_WAIT_MAX)) begin
        mem_timeout = 1'b1;
        state_d     = S_FETCH;
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end

    case (state_q)
      S_FETCH: begin
        MemRead = ~mem_timeout;
        ALUSrcB = ASB_FOUR;
        ALUOp   = ALU_ADD;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB = ASB_IMM_SH2;
        ALUOp   = ALU_ADD;
        EXTOP   = 1'b1;
        if (dec_r_alu)                            state_d = S_EXEC_R;
        else if (is_jr || is_jalr || is_j || is_jal) state_d = S_JUMP;
        else if (is_beq || is_bne)                state_d = S_BRANCH;
        else if (is_lw || is_sw)                  state_d = S_MEM_ADDR;
        else if (dec_i_alu)                       state_d = S_EXEC_I;
        else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ALUSrcA = dec_shift ? ASA_SHAMT : ASA_RS;
        ALUSrcB = ASB_RT;
        ALUOp   = dec_alu_op;
        state_d = S_WB_ALU;
      end
      S_EXEC_I: begin
        ALUSrcA = ASA_RS;
        ALUSrcB = ASB_IMM;
        ALUOp   = dec_alu_op;
        EXTOP   = dec_ext;
        state_d = S_WB_ALU;
      end
      S_WB_ALU: begin
        RegWrite = 1'b1;
        RegDst   = is_r ? REGDST_RD : REGDST_RT;
        state_d  = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA = ASA_RS;
        ALUSrcB = ASB_IMM;
        ALUOp   = ALU_ADD;
        EXTOP   = 1'b1;
        state_d = is_sw ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = ~mem_timeout;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = ~mem_timeout;
        if (mem_ready) state_d = S_FETCH;
      end
      S_WB_MEM: begin
        RegWrite = 1'b1;
        MemtoReg = M2R_MDR;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = ASA_RS;
        ALUSrcB = ASB_RT;
        ALUOp   = ALU_SUB;
        PCSrc   = PCSRC_ALUOUT;
        PCWrite = (is_beq & Zero) | (is_bne & ~Zero);
        state_d = S_FETCH;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = (is_j || is_jal) ? PCSRC_JUMP : PCSRC_RS;
        if (is_jal || is_jalr) begin
          RegWrite = 1'b1;
          MemtoReg = M2R_PC;
          RegDst   = is_jal ? REGDST_RA : REGDST_RD;
        end
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: directed instruction sequences push
// hand-computed per-cycle output vectors; a negedge monitor pops and compares.
module tb_multi_cycle_control;

  localparam int unsigned WMAX = 15;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_FETCH    = 4'd1;
  localparam logic [3:0] ST_DECODE   = 4'd2;
  localparam logic [3:0] ST_EXEC_R   = 4'd3;
  localparam logic [3:0] ST_EXEC_I   = 4'd4;
  localparam logic [3:0] ST_MEM_ADDR = 4'd5;
  localparam logic [3:0] ST_MEM_RD   = 4'd6;
  localparam logic [3:0] ST_MEM_WR   = 4'd7;
  localparam logic [3:0] ST_WB_MEM   = 4'd8;
  localparam logic [3:0] ST_WB_ALU   = 4'd9;
  localparam logic [3:0] ST_BRANCH   = 4'd10;
  localparam logic [3:0] ST_JUMP     = 4'd11;

  typedef struct packed {
    logic       pcw;
    logic [1:0] pcsrc;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       rw;
    logic [1:0] regdst;
    logic [1:0] m2r;
    logic [1:0] asa;
    logic [1:0] asb;
    logic [3:0] aluop;
    logic       extop;
    logic       ill;
    logic       to;
    logic [3:0] st;
  } obs_t;

  typedef struct {
    int    cyc;
    obs_t  val;
    obs_t  mask;
    string name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Opcode, Funct;
  logic       Zero, mem_ready;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, EXTOP, illegal, mem_timeout;
  logic [1:0] PCSrc, RegDst, MemtoReg, ALUSrcA, ALUSrcB;
  logic [3:0] ALUOp, state_o;

  obs_t act;
  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  multi_cycle_control #(.MEM_WAIT_MAX(WMAX)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .EXTOP(EXTOP), .illegal(illegal), .mem_timeout(mem_timeout),
    .state_o(state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign act = {PCWrite, PCSrc, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst,
                MemtoReg, ALUSrcA, ALUSrcB, ALUOp, EXTOP, illegal, mem_timeout, state_o};

  // Monitor: compare every expectation scheduled for the current cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      vectors++;
      if (e.cyc != cyc) begin
        miscompares++;
        $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d", e.name, e.cyc, cyc);
      end else if (((act ^ e.val) & e.mask) != '0) begin
        miscompares++;
        $display("FAIL %s: cycle %0d got %07h required %07h (mask %07h)",
                 e.name, cyc, act, e.val, e.mask);
      end
    end
  end

  function automatic obs_t z(input logic [3:0] st);
    obs_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic obs_t e_fetch(input logic rdy);
    obs_t o;
    o = z(ST_FETCH);
    o.mr = 1'b1; o.asb = 2'd1; o.aluop = 4'b0001;
    o.pcw = rdy; o.irw = rdy;
    return o;
  endfunction

  function automatic obs_t e_decode(input logic ill);
    obs_t o;
    o = z(ST_DECODE);
    o.asb = 2'd3; o.aluop = 4'b0001; o.extop = 1'b1; o.ill = ill;
    return o;
  endfunction

  function automatic obs_t e_mem_addr();
    obs_t o;
    o = z(ST_MEM_ADDR);
    o.asa = 2'd1; o.asb = 2'd2; o.aluop = 4'b0001; o.extop = 1'b1;
    return o;
  endfunction

  task automatic push_m(input string name, input obs_t v, input obs_t m);
    exp_t e;
    e.cyc = cyc; e.val = v; e.mask = m; e.name = name;
    sb.push_back(e);
  endtask

  // Expect v in the current cycle, then advance to just after the next edge.
  task automatic chk_step(input string name, input obs_t v);
    push_m(name, v, '1);
    @(posedge clk); #1;
  endtask

  task automatic front(input logic [5:0] op, input logic [5:0] fn, input string tag);
    Opcode = op; Funct = fn; mem_ready = 1'b1;
    chk_step({tag, "_fetch"}, e_fetch(1'b1));
    chk_step({tag, "_decode"}, e_decode(1'b0));
  endtask

  initial begin
    obs_t o, m;
    rst_n = 1'b0; Opcode = '0; Funct = '0; Zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    repeat (3) chk_step("reset_idle", z(ST_IDLE));
    rst_n = 1'b1;
    chk_step("release_idle", z(ST_IDLE));

    front(6'h00, 6'h20, "add");
    o = z(ST_EXEC_R); o.asa = 2'd1; o.aluop = 4'b0001;       chk_step("add_exec", o);
    o = z(ST_WB_ALU); o.rw = 1'b1; o.regdst = 2'd1;           chk_step("add_wb", o);

    front(6'h23, 6'h00, "lw");
    chk_step("lw_addr", e_mem_addr());
    o = z(ST_MEM_RD); o.iord = 1'b1; o.mr = 1'b1;
    mem_ready = 1'b0; chk_step("lw_wait0", o); chk_step("lw_wait1", o);
    mem_ready = 1'b1; chk_step("lw_rd_done", o);
    o = z(ST_WB_MEM); o.rw = 1'b1; o.m2r = 2'd1;              chk_step("lw_wb", o);

    front(6'h04, 6'h00, "beq_z1");
    Zero = 1'b1;
    o = z(ST_BRANCH); o.asa = 2'd1; o.aluop = 4'b0010; o.pcsrc = 2'd1; o.pcw = 1'b1;
    chk_step("beq_z1_br", o);
    front(6'h04, 6'h00, "beq_z0");
    Zero = 1'b0; o.pcw = 1'b0;                                chk_step("beq_z0_br", o);
    front(6'h05, 6'h00, "bne_z1");
    Zero = 1'b1; mem_ready = 1'b0; o.pcw = 1'b0;              chk_step("bne_z1_br", o);
    front(6'h05, 6'h00, "bne_z0");
    Zero = 1'b0; o.pcw = 1'b1;                                chk_step("bne_z0_br", o);

    front(6'h03, 6'h00, "jal");
    o = z(ST_JUMP); o.pcw = 1'b1; o.pcsrc = 2'd2; o.rw = 1'b1; o.regdst = 2'd2; o.m2r = 2'd2;
    chk_step("jal_jump", o);
    front(6'h00, 6'h09, "jalr");
    o.pcsrc = 2'd3; o.regdst = 2'd1;                          chk_step("jalr_jump", o);
    front(6'h00, 6'h08, "jr");
    o = z(ST_JUMP); o.pcw = 1'b1; o.pcsrc = 2'd3;             chk_step("jr_jump", o);

    front(6'h0D, 6'h00, "ori");
    o = z(ST_EXEC_I); o.asa = 2'd1; o.asb = 2'd2; o.aluop = 4'b0100;
    chk_step("ori_exec", o);
    o = z(ST_WB_ALU); o.rw = 1'b1;                            chk_step("ori_wb", o);
    front(6'h0A, 6'h00, "slti");
    o = z(ST_EXEC_I); o.asa = 2'd1; o.asb = 2'd2; o.aluop = 4'b0101; o.extop = 1'b1;
    chk_step("slti_exec", o);
    o = z(ST_WB_ALU); o.rw = 1'b1;                            chk_step("slti_wb", o);

    Opcode = 6'h3F; Funct = 6'h00; mem_ready = 1'b1;
    chk_step("ill_fetch", e_fetch(1'b1));
    chk_step("ill_decode", e_decode(1'b1));
    mem_ready = 1'b0; chk_step("ill_refetch_wait", e_fetch(1'b0));
    Opcode = 6'h2B; mem_ready = 1'b1; chk_step("sw_fetch", e_fetch(1'b1));
    chk_step("sw_decode", e_decode(1'b0));
    chk_step("sw_addr", e_mem_addr());

    // Stall past the limit: timeout in the (WMAX+1)-th MEM_WR cycle.
    mem_ready = 1'b0;
    o = z(ST_MEM_WR); o.iord = 1'b1; o.mw = 1'b1;
    repeat (WMAX) chk_step("sw_stall", o);
    o.to = 1'b1; m = '1; m.mw = 1'b0;
    push_m("sw_timeout", o, m);
    @(posedge clk); #1;
    chk_step("sw_timeout_refetch", e_fetch(1'b0));
    mem_ready = 1'b1; chk_step("sw_retry_fetch", e_fetch(1'b1));
    chk_step("sw_retry_decode", e_decode(1'b0));
    chk_step("sw_retry_addr", e_mem_addr());

    // Completion in the limit cycle wins over the timeout.
    mem_ready = 1'b0;
    o = z(ST_MEM_WR); o.iord = 1'b1; o.mw = 1'b1;
    repeat (WMAX) chk_step("sw_stall2", o);
    mem_ready = 1'b1; chk_step("sw_done_at_limit", o);
    chk_step("sw_after_done", e_fetch(1'b1));
    chk_step("sw3_decode", e_decode(1'b0));
    chk_step("sw3_addr", e_mem_addr());
    mem_ready = 1'b0; chk_step("sw3_wr", o);

    // Reset mid write: outputs drop in the same cycle.
    rst_n = 1'b0; chk_step("rst_mid_wr", z(ST_IDLE));
    rst_n = 1'b1; mem_ready = 1'b1; chk_step("rst2_release", z(ST_IDLE));
    chk_step("rst2_fetch", e_fetch(1'b1));

    repeat (2) @(negedge clk);
    while (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: expectation for cycle %0d never checked", sb[0].name, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
